// File: rtl/nested_loop_counter.sv
// N-deep nested loop counter: per-loop bound, stride and count mode (wrap, bounce, down).
// Produces the loop indices and a strided linear address for tile walks.
module nested_loop_counter #(
  parameter int unsigned NUM_LOOPS = 3,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic                        en_i,
  input  logic [NUM_LOOPS*WIDTH-1:0]  bound_i,
  input  logic [NUM_LOOPS*ADDR_W-1:0] stride_i,
  input  logic [NUM_LOOPS*2-1:0]      mode_i,
  output logic [NUM_LOOPS*WIDTH-1:0]  cnt_o,
  output logic [ADDR_W-1:0]           addr_o,
  output logic                        valid_o,
  output logic [NUM_LOOPS-1:0]        last_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_BOUNCE   = 2'b01,
    MODE_DOWN     = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    cnt_q    [NUM_LOOPS];
  logic [WIDTH-1:0]    cnt_d    [NUM_LOOPS];
  logic [WIDTH-1:0]    bound_q  [NUM_LOOPS];
  logic [ADDR_W-1:0]   stride_q [NUM_LOOPS];
  mode_e               mode_q   [NUM_LOOPS];
  logic [NUM_LOOPS-1:0] dir_q, dir_d;   // bounce direction, 1 = counting down
  logic [NUM_LOOPS-1:0] last_raw;
  logic                load_cfg;
  logic                carry;
  logic [ADDR_W-1:0]   addr_sum;

  always_comb begin
    last_raw = '0;
    for (int unsigned k = 0; k < NUM_LOOPS; k++) begin
      case (mode_q[k])
        MODE_BOUNCE: last_raw[k] = (bound_q[k] == '0) || ((cnt_q[k] == '0) && dir_q[k]);
        MODE_DOWN:   last_raw[k] = (cnt_q[k] == '0);
        default:     last_raw[k] = (cnt_q[k] == bound_q[k]);
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    load_cfg = 1'b0;
    carry    = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      for (int unsigned k = 0; k < NUM_LOOPS; k++) cnt_d[k] = '0;
      dir_d = '0;
    end else if (start_i) begin
      state_d  = ST_RUN;
      load_cfg = 1'b1;
      dir_d    = '0;
      for (int unsigned k = 0; k < NUM_LOOPS; k++) begin
        cnt_d[k] = (mode_i[2*k +: 2] == 2'b10) ? bound_i[k*WIDTH +: WIDTH] : '0;
      end
    end else if (en_i && (state_q == ST_RUN)) begin
      if (&last_raw) begin
        state_d = ST_DONE;
      end else begin
        // Ripple carry: loop k steps only while every inner loop sits at its last position.
        carry = 1'b1;
        for (int unsigned k = 0; k < NUM_LOOPS; k++) begin
          if (carry) begin
            case (mode_q[k])
              MODE_BOUNCE: begin
                if (!dir_q[k]) begin
                  if (cnt_q[k] == bound_q[k]) begin
                    if (bound_q[k] != '0) begin
                      cnt_d[k] = cnt_q[k] - WIDTH'(1);
                      dir_d[k] = 1'b1;
                    end
                  end else begin
                    cnt_d[k] = cnt_q[k] + WIDTH'(1);
                  end
                end else if (cnt_q[k] == '0) begin
                  dir_d[k] = 1'b0;
                end else begin
                  cnt_d[k] = cnt_q[k] - WIDTH'(1);
                end
              end
              MODE_DOWN: cnt_d[k] = (cnt_q[k] == '0) ? bound_q[k] : cnt_q[k] - WIDTH'(1);
              default:   cnt_d[k] = (cnt_q[k] == bound_q[k]) ? '0 : cnt_q[k] + WIDTH'(1);
            endcase
          end
          carry = carry & last_raw[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      dir_q   <= '0;
      for (int unsigned k = 0; k < NUM_LOOPS; k++) begin
        cnt_q[k]    <= '0;
        bound_q[k]  <= '0;
        stride_q[k] <= '0;
        mode_q[k]   <= MODE_WRAP;
      end
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      for (int unsigned k = 0; k < NUM_LOOPS; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (load_cfg) begin
          bound_q[k]  <= bound_i[k*WIDTH +: WIDTH];
          stride_q[k] <= stride_i[k*ADDR_W +: ADDR_W];
          mode_q[k]   <= mode_e'(mode_i[2*k +: 2]);
        end
      end
    end
  end

  always_comb begin
    addr_sum = '0;
    cnt_o    = '0;
    for (int unsigned k = 0; k < NUM_LOOPS; k++) begin
      addr_sum = addr_sum + ADDR_W'(cnt_q[k]) * stride_q[k];
      cnt_o[k*WIDTH +: WIDTH] = cnt_q[k];
    end
  end

  assign addr_o  = addr_sum;
  // Stale config after reset/clear would otherwise flag loops as last while idle.
  assign last_o  = (state_q == ST_IDLE) ? '0 : last_raw;
  assign valid_o = (state_q == ST_RUN);
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE);

endmodule
